// File: rtl/seg7_bcd_scan_counter_if.sv
// rtl/seg7_bcd_scan_counter_if.sv - control and display bus of the scanned BCD counter
interface seg7_bcd_scan_counter_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    up_down;
    logic                    clear;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_value;
    logic [4*NUM_DIGITS-1:0] count_bcd;
    logic [6:0]              segments;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    tick;
    logic                    wrap;

    modport master (
        output enable, up_down, clear, load, load_value,
        input  count_bcd, segments, digit_sel, tick, wrap
    );

    modport slave (
        input  enable, up_down, clear, load, load_value,
        output count_bcd, segments, digit_sel, tick, wrap
    );
endinterface

// File: rtl/seg7_bcd_scan_counter.sv
// rtl/seg7_bcd_scan_counter.sv - prescaled up/down BCD counter with multiplexed 7-segment scan
module seg7_bcd_scan_counter #(
    parameter int TICK_COUNT    = 10_000_000,
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_COUNT    = 10_000,
    parameter int BLANK_LEADING = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    seg7_bcd_scan_counter_if.slave  bus
);
    localparam int PW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_COUNT - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'h3F;
            4'd1:    seg_encode = 7'h06;
            4'd2:    seg_encode = 7'h5B;
            4'd3:    seg_encode = 7'h4F;
            4'd4:    seg_encode = 7'h66;
            4'd5:    seg_encode = 7'h6D;
            4'd6:    seg_encode = 7'h7D;
            4'd7:    seg_encode = 7'h07;
            4'd8:    seg_encode = 7'h7F;
            4'd9:    seg_encode = 7'h6F;
            default: seg_encode = 7'h00;
        endcase
    endfunction

    logic [PW-1:0]         presc_q;
    logic [CW-1:0]         count_q;
    logic                  tick_q;
    logic                  wrap_q;
    logic [SW-1:0]         scan_div_q;
    logic [IW-1:0]         scan_idx_q;
    logic [NUM_DIGITS-1:0] digit_sel_q;
    logic [6:0]            segments_q;

    logic [CW-1:0] count_up;
    logic [CW-1:0] count_dn;
    logic [CW-1:0] load_clamped;
    logic          wrap_up;
    logic          wrap_dn;
    logic          carry;
    logic          borrow;
    logic [3:0]    d;

    // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
    always_comb begin
        count_up     = count_q;
        count_dn     = count_q;
        load_clamped = bus.load_value;
        carry        = 1'b1;
        borrow       = 1'b1;
        d            = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = count_q[4*i +: 4];
            if (carry) begin
                if (d >= 4'd9) begin
                    count_up[4*i +: 4] = 4'd0;
                end else begin
                    count_up[4*i +: 4] = d + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (d == 4'd0) begin
                    count_dn[4*i +: 4] = 4'd9;
                end else begin
                    count_dn[4*i +: 4] = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (bus.load_value[4*i +: 4] > 4'd9) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
        wrap_up = carry;
        wrap_dn = borrow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (bus.clear) begin
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (bus.load) begin
            presc_q <= '0;
            count_q <= load_clamped;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (bus.enable) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q <= '0;
                    tick_q  <= 1'b1;
                    if (bus.up_down) begin
                        count_q <= count_up;
                        wrap_q  <= wrap_up;
                    end else begin
                        count_q <= count_dn;
                        wrap_q  <= wrap_dn;
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    logic [IW-1:0]         next_idx;
    logic [NUM_DIGITS-1:0] digit_sel_d;
    logic [6:0]            segments_d;
    logic                  zero_above;

    // Walk from the top digit down so zero_above means "this digit and all higher ones are 0".
    always_comb begin
        next_idx = scan_idx_q;
        if (scan_div_q == SCAN_LAST) begin
            next_idx = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
        digit_sel_d = '0;
        segments_d  = 7'h00;
        zero_above  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (count_q[4*i +: 4] == 4'd0);
            if (IW'(i) == next_idx) begin
                digit_sel_d[i] = 1'b1;
                if ((BLANK_LEADING != 0) && (i != 0) && zero_above) begin
                    segments_d = 7'h00;
                end else begin
                    segments_d = seg_encode(count_q[4*i +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_div_q  <= '0;
            scan_idx_q  <= '0;
            digit_sel_q <= NUM_DIGITS'(1);
            segments_q  <= 7'h3F;
        end else begin
            scan_div_q  <= (scan_div_q == SCAN_LAST) ? '0 : scan_div_q + 1'b1;
            scan_idx_q  <= next_idx;
            digit_sel_q <= digit_sel_d;
            segments_q  <= segments_d;
        end
    end

    assign bus.count_bcd = count_q;
    assign bus.tick      = tick_q;
    assign bus.wrap      = wrap_q;
    assign bus.digit_sel = digit_sel_q;
    assign bus.segments  = segments_q;
endmodule

// File: tb/tb_seg7_bcd_scan_counter.sv
// tb/tb_seg7_bcd_scan_counter.sv - directed bench for the scanned BCD counter
module tb_seg7_bcd_scan_counter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    seg7_bcd_scan_counter_if #(.NUM_DIGITS(2)) bus_a ();
    seg7_bcd_scan_counter_if #(.NUM_DIGITS(2)) bus_b ();

    assign bus_b.enable     = bus_a.enable;
    assign bus_b.up_down    = bus_a.up_down;
    assign bus_b.clear      = bus_a.clear;
    assign bus_b.load       = bus_a.load;
    assign bus_b.load_value = bus_a.load_value;

    seg7_bcd_scan_counter #(
        .TICK_COUNT(4), .NUM_DIGITS(2), .SCAN_COUNT(3), .BLANK_LEADING(0)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );

    seg7_bcd_scan_counter #(
        .TICK_COUNT(4), .NUM_DIGITS(2), .SCAN_COUNT(3), .BLANK_LEADING(1)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(output int n);
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            done = bus_a.tick;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        bus_a.load = 1'b1;
        bus_a.load_value = v;
        step(1);
        bus_a.load = 1'b0;
    endtask

    task automatic find_slot(input logic [1:0] from_sel, input logic [1:0] to_sel, output logic found);
        logic [1:0] prev;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            prev = bus_a.digit_sel;
            step(1);
            found = (prev == from_sel) && (bus_a.digit_sel == to_sel);
        end
    endtask

    initial begin
        int   n;
        logic saw_tick;
        logic found;

        reset = 1'b1;
        bus_a.enable = 1'b1;
        bus_a.up_down = 1'b1;
        bus_a.clear = 1'b0;
        bus_a.load = 1'b0;
        bus_a.load_value = 8'h00;
        step(2);
        check("rst_count", 16'(bus_a.count_bcd), 16'h00);
        check("rst_sel", 16'(bus_a.digit_sel), 16'h01);
        check("rst_seg", 16'(bus_a.segments), 16'h3F);
        check("rst_tick", 16'(bus_a.tick), 16'h0);
        check("rst_wrap", 16'(bus_a.wrap), 16'h0);

        reset = 1'b0;
        wait_tick(n);
        check("tick1_lat", 16'(n), 16'd4);
        check("tick1_count", 16'(bus_a.count_bcd), 16'h01);
        check("tick1_wrap", 16'(bus_a.wrap), 16'h0);
        wait_tick(n);
        check("tick2_lat", 16'(n), 16'd4);
        check("tick2_count", 16'(bus_a.count_bcd), 16'h02);
        wait_tick(n);
        check("tick3_lat", 16'(n), 16'd4);
        check("tick3_count", 16'(bus_a.count_bcd), 16'h03);
        check("tick3_wrap", 16'(bus_a.wrap), 16'h0);

        do_load(8'h98);
        check("load98_count", 16'(bus_a.count_bcd), 16'h98);
        check("load98_tick", 16'(bus_a.tick), 16'h0);
        wait_tick(n);
        check("up99_lat", 16'(n), 16'd4);
        check("up99_count", 16'(bus_a.count_bcd), 16'h99);
        check("up99_wrap", 16'(bus_a.wrap), 16'h0);
        wait_tick(n);
        check("up00_count", 16'(bus_a.count_bcd), 16'h00);
        check("up00_wrap", 16'(bus_a.wrap), 16'h1);

        bus_a.up_down = 1'b0;
        do_load(8'h00);
        wait_tick(n);
        check("dn99_lat", 16'(n), 16'd4);
        check("dn99_count", 16'(bus_a.count_bcd), 16'h99);
        check("dn99_wrap", 16'(bus_a.wrap), 16'h1);
        bus_a.up_down = 1'b1;

        do_load(8'hA5);
        check("clamp_count", 16'(bus_a.count_bcd), 16'h95);
        bus_a.clear = 1'b1;
        bus_a.load = 1'b1;
        bus_a.load_value = 8'h33;
        step(1);
        bus_a.clear = 1'b0;
        bus_a.load = 1'b0;
        check("clrld_count", 16'(bus_a.count_bcd), 16'h00);
        check("clrld_tick", 16'(bus_a.tick), 16'h0);

        step(2);
        bus_a.enable = 1'b0;
        saw_tick = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (bus_a.tick) saw_tick = 1'b1;
        end
        check("pause_count", 16'(bus_a.count_bcd), 16'h00);
        check("pause_tick", 16'(saw_tick), 16'h0);
        bus_a.enable = 1'b1;
        wait_tick(n);
        check("resume_lat", 16'(n), 16'd2);
        check("resume_count", 16'(bus_a.count_bcd), 16'h01);

        bus_a.enable = 1'b0;
        do_load(8'h47);
        find_slot(2'b10, 2'b01, found);
        check("scan47_found", 16'(found), 16'h1);
        for (int k = 0; k < 6; k++) begin
            check("scan47_sel", 16'(bus_a.digit_sel), (k < 3) ? 16'h01 : 16'h02);
            check("scan47_seg", 16'(bus_a.segments), (k < 3) ? 16'h07 : 16'h66);
            check("scan47_seg_blank", 16'(bus_b.segments), (k < 3) ? 16'h07 : 16'h66);
            step(1);
        end
        check("scan47_wrapback", 16'(bus_a.digit_sel), 16'h01);

        do_load(8'h05);
        find_slot(2'b01, 2'b10, found);
        check("blank_found", 16'(found), 16'h1);
        check("blank_seg", 16'(bus_b.segments), 16'h00);
        check("noblank_seg", 16'(bus_a.segments), 16'h3F);
        check("blank_sel", 16'(bus_b.digit_sel), 16'h02);
        step(3);
        check("blank_d0_sel", 16'(bus_b.digit_sel), 16'h01);
        check("blank_d0_seg", 16'(bus_b.segments), 16'h6D);
        check("noblank_d0_seg", 16'(bus_a.segments), 16'h6D);

        bus_a.enable = 1'b1;
        wait_tick(n);
        check("prerst_count", 16'(bus_a.count_bcd), 16'h06);
        step(3);
        reset = 1'b1;
        step(1);
        check("mid_rst_count", 16'(bus_a.count_bcd), 16'h00);
        check("mid_rst_tick", 16'(bus_a.tick), 16'h0);
        check("mid_rst_wrap", 16'(bus_a.wrap), 16'h0);
        check("mid_rst_sel", 16'(bus_a.digit_sel), 16'h01);
        check("mid_rst_seg", 16'(bus_a.segments), 16'h3F);
        check("mid_rst_seg_blank", 16'(bus_b.segments), 16'h3F);
        reset = 1'b0;
        step(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/seg7_bcd_scan_counter.md
Name: seg7_bcd_scan_counter

Overview:
- Parametrised successor to the single-digit seconds display.
- A prescaled, NUM_DIGITS-wide BCD counter that counts up or down, with load, clear and pause controls.
- Drives a time-multiplexed common seven-segment bus: one shared segment vector plus a one-hot digit select, with optional leading-zero blanking.
- Sits between the top-level pads and the user switches; tick and wrap pulses are exported for chaining.

Parameters:
- TICK_COUNT, 10_000_000: clk cycles per count step (>=1); prescaler width = max(1, clog2(TICK_COUNT)).
- NUM_DIGITS, 4: number of BCD digits (1..8).
- SCAN_COUNT, 10_000: clk cycles per display digit slot (>=1).
- BLANK_LEADING, 0: 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = prescaler runs; 0 = pause (prescaler and count hold)
- up_down  in  1  1 = increment, 0 = decrement, sampled at the tick edge
- clear  in  1  synchronous clear of count and prescaler
- load  in  1  synchronous load of load_value
- load_value  in  4*NUM_DIGITS  BCD load data; digit i = bits [4i+3:4i]
- count_bcd  out  4*NUM_DIGITS  current count, registered
- segments  out  7  bit0=a .. bit6=g, active-high, registered
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable, registered
- tick  out  1  one-cycle pulse on the cycle a count step becomes visible
- wrap  out  1  one-cycle pulse coincident with tick when the count wrapped

Behaviour:
Reset values:
- count 0, prescaler 0, scan divider 0, scan index 0.
- digit_sel = 1 (digit 0), segments = 0x3F, tick 0, wrap 0.

Priority per clock edge: reset > clear > load > step.
- clear: count and prescaler go to 0. tick and wrap stay 0 that cycle.
- load: count gets load_value, with any nibble >9 clamped to 9. Prescaler goes to 0. tick and wrap stay 0.
- clear or load while enable is low still take effect.

Prescaler:
- When enable is 1, counts 0..TICK_COUNT-1.
- At the terminal value, the next edge returns it to 0 and performs one step.
- When enable is 0, it holds its value. No partial progress is lost on pause.

Step (BCD arithmetic, per-digit carry/borrow chain):
- Up: digit 9 -> 0 with carry into the next digit. All-9s -> all-0s sets wrap.
- Down: digit 0 -> 9 with borrow into the next digit. All-0s -> all-9s sets wrap.
- tick is registered high for exactly one cycle, the same cycle the new count_bcd appears. wrap is likewise registered high in that same cycle, only if a wrap occurred.
- With TICK_COUNT=1 and enable held high, a step occurs every cycle and tick stays high continuously.

Display scan (free-running, independent of enable, clear and load):
- Scan divider counts 0..SCAN_COUNT-1. On its terminal value the scan index advances, modulo NUM_DIGITS.
- Each edge registers digit_sel = onehot(next index) and segments = encode(count digit[next index]). count is the value before that edge's update, so displayed data lags count_bcd by one cycle.
- Encoding, 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- Blanking: when BLANK_LEADING=1, digit i>0 is shown as 0x00 if it and all higher digits are 0.

No combinational path from any input to any output.

Test Plan:
- Params TICK_COUNT=4, NUM_DIGITS=2, SCAN_COUNT=3. Release reset with enable=1, up_down=1 -> tick on cycles 4, 8, 12…; count_bcd 0x01, 0x02, 0x03; wrap=0.
- Load 0x98, then count up 2 steps -> 0x99, then 0x00 with wrap=1 on the same cycle as tick. Load 0x00, then down 1 step -> 0x99 with wrap=1.
- Load 0xA5 -> count_bcd=0x95 (clamped). Assert clear and load together -> count 0x00 (clear wins), no tick.
- Pause: drop enable with the prescaler at 2 for 10 cycles -> count and prescaler hold. Raise enable -> next tick exactly 2 cycles later.
- Scan: count 0x47 -> digit_sel 01/segments 0x07 for 3 cycles, then 10/0x66 for 3 cycles, repeating. With BLANK_LEADING=1 and count 0x05 -> digit 1 slot shows segments 0x00.
- Assert reset mid-count and mid-scan -> next cycle count 0, digit_sel 01, segments 0x3F, tick 0, wrap 0.
